// File: rtl/hazard_unit_mc_pkg.sv
// rtl/hazard_unit_mc_pkg.sv - shared types for the multi-cycle hazard unit
package hazard_unit_mc_pkg;

  // Operand source selected for the EX stage ALU inputs
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } forward_t;

  // Multi-cycle EX unit occupancy tracker
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_unit_mc_fwd_select.sv
// rtl/hazard_unit_mc_fwd_select.sv - forwarding source select for one EX operand
module hazard_unit_mc_fwd_select
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output forward_t          fwd
);

  // x0 never forwards; the younger result in M wins over W
  always_comb begin
    fwd = FWD_NONE;
    if (rs != '0) begin
      if (reg_write_m && (rs == rd_m)) begin
        fwd = FWD_M;
      end else if (reg_write_w && (rs == rd_w)) begin
        fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with multi-cycle EX and memory wait
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MC_LAT      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              load_e,
  input  logic              mc_op_e,
  input  logic              pc_src_e,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  output forward_t          forward_a_e,
  output forward_t          forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              mc_busy,
  output logic              mem_timeout
);

  localparam int   CW    = $clog2(MC_LAT + 1);
  localparam int   WW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic MC_EN = (MC_LAT > 1);

  mc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  forward_t fwd_a, fwd_b;
  logic     memw, mcs, lu, br, stall_e_int;

  hazard_unit_mc_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a)
  );

  hazard_unit_mc_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b)
  );

  // Hazard conditions; load-use and branch only act when EX is free to advance
  always_comb begin
    memw        = mem_req_m & ~mem_ready_m;
    mcs         = ((state_q == MC_IDLE) & mc_op_e & MC_EN) |
                  ((state_q == MC_BUSY) & (cnt_q != CW'(1)));
    stall_e_int = memw | mcs;
    lu          = load_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d)) & ~stall_e_int;
    br          = pc_src_e & ~stall_e_int;
  end

  // Multi-cycle FSM next state; a memory wait freezes both state and count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!memw) begin
      case (state_q)
        MC_IDLE: begin
          if (mc_op_e && MC_EN) begin
            state_d = MC_BUSY;
            cnt_d   = CW'(MC_LAT - 1);
          end
        end
        MC_BUSY: begin
          if (cnt_q == CW'(1)) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = MC_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Consecutive wait-cycle counter and sticky timeout flag
  always_comb begin
    wcnt_d        = '0;
    mem_timeout_d = mem_timeout_q;
    if (memw) begin
      wcnt_d = (wcnt_q == WW'(MEM_TIMEOUT)) ? wcnt_q : wcnt_q + WW'(1);
    end
    if (wcnt_q == WW'(MEM_TIMEOUT)) begin
      mem_timeout_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MC_IDLE;
      cnt_q         <= '0;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Output drive; branch redirect overrides the load-use front-end stall
  always_comb begin
    forward_a_e = FWD_NONE;
    forward_b_e = FWD_NONE;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    mc_busy     = 1'b0;
    if (!rst) begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      stall_f     = stall_e_int | (lu & ~br);
      stall_d     = stall_e_int | (lu & ~br);
      stall_e     = stall_e_int;
      stall_m     = memw;
      flush_d     = br;
      flush_e     = br | lu;
      flush_m     = mcs & ~memw;
      flush_w     = memw;
      mc_busy     = (state_q == MC_BUSY);
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard bench for hazard_unit_mc
module tb_hazard_unit_mc;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, mc_op_e, pc_src_e, mem_req_m, mem_ready_m;
  } in_t;

  // {fa, fb, sf, sd, se, sm, fd, fe, fm, fw, busy, tmo}
  typedef struct packed {
    logic [1:0] fa, fb;
    logic [9:0] f;
  } out_t;

  logic clk = 1'b0;
  in_t  vin;
  logic [1:0] forward_a_e, forward_b_e;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mc_busy, mem_timeout;

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MC_LAT(3), .MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (vin.rst),
    .rs1_d       (vin.rs1_d),
    .rs2_d       (vin.rs2_d),
    .rs1_e       (vin.rs1_e),
    .rs2_e       (vin.rs2_e),
    .rd_e        (vin.rd_e),
    .rd_m        (vin.rd_m),
    .rd_w        (vin.rd_w),
    .reg_write_m (vin.reg_write_m),
    .reg_write_w (vin.reg_write_w),
    .load_e      (vin.load_e),
    .mc_op_e     (vin.mc_op_e),
    .pc_src_e    (vin.pc_src_e),
    .mem_req_m   (vin.mem_req_m),
    .mem_ready_m (vin.mem_ready_m),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
    .flush_w     (flush_w),
    .mc_busy     (mc_busy),
    .mem_timeout (mem_timeout)
  );

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.mem_ready_m = 1'b1;
    return v;
  endfunction

  function automatic out_t ex(input logic [1:0] fa, input logic [1:0] fb, input logic [9:0] f);
    out_t o;
    o.fa = fa;
    o.fb = fb;
    o.f  = f;
    return o;
  endfunction

  // One cycle of stimulus plus its expected response
  task automatic cyc(input string nm, input in_t v, input out_t e);
    @(posedge clk);
    #1;
    vin = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      out_t  e;
      out_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_m, flush_w, mc_busy, mem_timeout};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    vin = idle();

    // Reset with hazards present: everything held quiet
    v = idle(); v.rst = 1; v.mem_req_m = 1; v.mem_ready_m = 0; v.mc_op_e = 1;
    v.rs1_e = 5; v.rd_m = 5; v.reg_write_m = 1;
    cyc("reset0", v, ex(2'b00, 2'b00, 10'b0000000000));
    cyc("reset1", v, ex(2'b00, 2'b00, 10'b0000000000));
    v = idle();
    cyc("idle", v, ex(2'b00, 2'b00, 10'b0000000000));

    // Forwarding
    v = idle(); v.rs1_e = 5; v.rd_m = 5; v.reg_write_m = 1; v.rs2_e = 6; v.rd_w = 6; v.reg_write_w = 1;
    cyc("fwd_m_w", v, ex(2'b10, 2'b01, 10'b0000000000));
    v = idle(); v.rs1_e = 0; v.rd_m = 0; v.reg_write_m = 1;
    cyc("fwd_x0", v, ex(2'b00, 2'b00, 10'b0000000000));
    v = idle(); v.rs1_e = 7; v.rd_m = 7; v.rd_w = 7; v.reg_write_m = 1; v.reg_write_w = 1;
    cyc("fwd_prio", v, ex(2'b10, 2'b00, 10'b0000000000));
    v.reg_write_m = 0;
    cyc("fwd_w_only", v, ex(2'b01, 2'b00, 10'b0000000000));

    // Load-use: stall, bubble, then forward from W
    v = idle(); v.load_e = 1; v.rd_e = 6; v.rs2_d = 6;
    cyc("lu_stall", v, ex(2'b00, 2'b00, 10'b1100010000));
    v = idle(); v.rs2_d = 6; v.rd_m = 6; v.reg_write_m = 1;
    cyc("lu_bubble", v, ex(2'b00, 2'b00, 10'b0000000000));
    v = idle(); v.rs2_e = 6; v.rd_w = 6; v.reg_write_w = 1; v.rd_m = 9;
    cyc("lu_fwd_w", v, ex(2'b00, 2'b01, 10'b0000000000));
    v = idle(); v.load_e = 1; v.rd_e = 0; v.rs1_d = 0;
    cyc("lu_x0", v, ex(2'b00, 2'b00, 10'b0000000000));

    // Multi-cycle op, no memory wait
    v = idle(); v.mc_op_e = 1;
    cyc("mc_enter", v, ex(2'b00, 2'b00, 10'b1110001000));
    v = idle();
    cyc("mc_busy2", v, ex(2'b00, 2'b00, 10'b1110001010));
    cyc("mc_busy1", v, ex(2'b00, 2'b00, 10'b0000000010));
    cyc("mc_done", v, ex(2'b00, 2'b00, 10'b0000000000));

    // Multi-cycle op frozen by four memory wait cycles
    v = idle(); v.mc_op_e = 1;
    cyc("mcw_enter", v, ex(2'b00, 2'b00, 10'b1110001000));
    for (int k = 1; k <= 4; k++) begin
      v = idle(); v.mem_req_m = 1; v.mem_ready_m = 0;
      if (k == 2) begin
        v.load_e = 1; v.rd_e = 6; v.rs1_d = 6;
      end
      cyc($sformatf("mcw_wait%0d", k), v, ex(2'b00, 2'b00, 10'b1111000110));
    end
    v = idle(); v.mem_req_m = 1; v.pc_src_e = 1;
    cyc("mcw_busy2_br", v, ex(2'b00, 2'b00, 10'b1110001010));
    v = idle();
    cyc("mcw_busy1", v, ex(2'b00, 2'b00, 10'b0000000010));
    cyc("mcw_done", v, ex(2'b00, 2'b00, 10'b0000000000));

    // Memory wait blocks entry to BUSY
    v = idle(); v.mc_op_e = 1; v.mem_req_m = 1; v.mem_ready_m = 0;
    cyc("mce_wait", v, ex(2'b00, 2'b00, 10'b1111000100));
    v.mem_ready_m = 1;
    cyc("mce_enter", v, ex(2'b00, 2'b00, 10'b1110001000));
    v = idle();
    cyc("mce_busy2", v, ex(2'b00, 2'b00, 10'b1110001010));
    cyc("mce_busy1", v, ex(2'b00, 2'b00, 10'b0000000010));

    // Twenty-cycle memory wait trips the timeout
    v = idle(); v.mem_req_m = 1; v.mem_ready_m = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc($sformatf("tmo_wait%0d", k), v, ex(2'b00, 2'b00, {9'b111100010, (k >= 17)}));
    end
    v = idle();
    cyc("tmo_sticky0", v, ex(2'b00, 2'b00, 10'b0000000001));
    cyc("tmo_sticky1", v, ex(2'b00, 2'b00, 10'b0000000001));

    // Branch overrides load-use
    v = idle(); v.pc_src_e = 1; v.load_e = 1; v.rd_e = 6; v.rs1_d = 6;
    cyc("br_lu", v, ex(2'b00, 2'b00, 10'b0000110001));

    // Reset in the middle of BUSY
    v = idle(); v.mc_op_e = 1;
    cyc("rst_enter", v, ex(2'b00, 2'b00, 10'b1110001001));
    v = idle(); v.rst = 1; v.rs1_e = 5; v.rd_m = 5; v.reg_write_m = 1;
    cyc("rst_busy", v, ex(2'b00, 2'b00, 10'b0000000001));
    v = idle();
    cyc("rst_after", v, ex(2'b00, 2'b00, 10'b0000000000));

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
